// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants for the 3x3 output-stationary systolic array.
// Holds default operand/accumulator widths and the grid dimension.
package systolic_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 17;
    localparam int N      = 3;

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one multiply-accumulate cell; forwards a right and b down.
// Ports: clk, reset (async, active-high), a_in/b_in operands,
//        a_out/b_out registered operands, acc running accumulator.
// Optional macro SYSTOLIC_ACC_SAT_EN: saturate acc at all-ones instead of wrapping.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int P_DATA_W = DATA_W,
    parameter int P_ACC_W  = ACC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [P_DATA_W-1:0] a_in,
    input  logic [P_DATA_W-1:0] b_in,
    output logic [P_DATA_W-1:0] a_out,
    output logic [P_DATA_W-1:0] b_out,
    output logic [P_ACC_W-1:0]  acc
);

    logic [P_DATA_W-1:0]   r_a;
    logic [P_DATA_W-1:0]   r_b;
    logic [P_ACC_W-1:0]    r_acc;
    logic [2*P_DATA_W-1:0] w_prod;
    logic [P_ACC_W-1:0]    w_next;

    assign w_prod = a_in * b_in;

`ifdef SYSTOLIC_ACC_SAT_EN
    // One extra bit catches the carry; a carry means the sum overflowed.
    logic [P_ACC_W:0] w_sum;
    assign w_sum  = {1'b0, r_acc} + (P_ACC_W+1)'(w_prod);
    assign w_next = w_sum[P_ACC_W] ? '1 : w_sum[P_ACC_W-1:0];
`else
    assign w_next = r_acc + P_ACC_W'(w_prod);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_acc <= w_next;
        end
    end

    assign a_out = r_a;
    assign b_out = r_b;
    assign acc   = r_acc;

endmodule

// File: rtl/systolic_array_3x3.sv
// systolic_array_3x3: 3x3 output-stationary systolic array, C = A x B.
// Ports: clk, reset (async, active-high); a1..a3 skewed A rows from the left;
//        b1..b3 skewed B columns from the top; c1..c9 PE accumulators, row-major.
// Optional macro SYSTOLIC_ACC_SAT_EN: accumulators saturate instead of wrapping.
module systolic_array_3x3
    import systolic_pkg::*;
#(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int ACC_W  = systolic_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] b3,
    output logic [ACC_W-1:0]  c1,
    output logic [ACC_W-1:0]  c2,
    output logic [ACC_W-1:0]  c3,
    output logic [ACC_W-1:0]  c4,
    output logic [ACC_W-1:0]  c5,
    output logic [ACC_W-1:0]  c6,
    output logic [ACC_W-1:0]  c7,
    output logic [ACC_W-1:0]  c8,
    output logic [ACC_W-1:0]  c9
);

    // w_a[i][j] feeds PE(i,j) from the left; column N is the unused spill-out.
    // w_b[i][j] feeds PE(i,j) from above; row N is the unused spill-out.
    logic [DATA_W-1:0] w_a   [N][N+1];
    logic [DATA_W-1:0] w_b   [N+1][N];
    logic [ACC_W-1:0]  w_acc [N][N];
    logic [DATA_W-1:0] w_a_ext [N];
    logic [DATA_W-1:0] w_b_ext [N];
    logic              w_unused;

    assign w_a_ext[0] = a1;
    assign w_a_ext[1] = a2;
    assign w_a_ext[2] = a3;
    assign w_b_ext[0] = b1;
    assign w_b_ext[1] = b2;
    assign w_b_ext[2] = b3;

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign w_a[i][0] = w_a_ext[i];
        assign w_b[0][i] = w_b_ext[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .P_DATA_W (DATA_W),
                .P_ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .a_in  (w_a[i][j]),
                .b_in  (w_b[i][j]),
                .a_out (w_a[i][j+1]),
                .b_out (w_b[i+1][j]),
                .acc   (w_acc[i][j])
            );
        end
    end

    // Operands leaving the far edges have no consumer.
    assign w_unused = ^{w_a[0][N], w_a[1][N], w_a[2][N],
                        w_b[N][0], w_b[N][1], w_b[N][2]};

    assign c1 = w_acc[0][0];
    assign c2 = w_acc[0][1];
    assign c3 = w_acc[0][2];
    assign c4 = w_acc[1][0];
    assign c5 = w_acc[1][1];
    assign c6 = w_acc[1][2];
    assign c7 = w_acc[2][0];
    assign c8 = w_acc[2][1];
    assign c9 = w_acc[2][2];

endmodule

// File: tb/tb_systolic_array_3x3.sv
// tb_systolic_array_3x3: directed self-checking bench for systolic_array_3x3.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_systolic_array_3x3;

    logic        clk;
    logic        reset;
    logic [7:0]  a1, a2, a3, b1, b2, b3;
    logic [16:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
    logic [16:0] cv [9];

    int errors;
    int checks;

    // Skewed stimulus (a1,a2,a3,b1,b2,b3) for A=[1 2 3;4 5 6;7 8 9],
    // B=[2 1 3;4 5 7;6 9 8].
    int unsigned tbl [5][6] = '{
        '{1, 0, 0, 2, 0, 0},
        '{2, 4, 0, 4, 1, 0},
        '{3, 5, 7, 6, 5, 3},
        '{0, 6, 8, 0, 9, 7},
        '{0, 0, 9, 0, 0, 8}
    };
    int unsigned exp_c [9] = '{28, 38, 41, 64, 83, 95, 100, 128, 149};

    systolic_array_3x3 dut (
        .clk   (clk),
        .reset (reset),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .b1    (b1),
        .b2    (b2),
        .b3    (b3),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c5    (c5),
        .c6    (c6),
        .c7    (c7),
        .c8    (c8),
        .c9    (c9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cv[0] = c1;
        cv[1] = c2;
        cv[2] = c3;
        cv[3] = c4;
        cv[4] = c5;
        cv[5] = c6;
        cv[6] = c7;
        cv[7] = c8;
        cv[8] = c9;
    end

    task automatic set_in(input int unsigned x1, input int unsigned x2,
                          input int unsigned x3, input int unsigned y1,
                          input int unsigned y2, input int unsigned y3);
        a1 = 8'(x1);
        a2 = 8'(x2);
        a3 = 8'(x3);
        b1 = 8'(y1);
        b2 = 8'(y2);
        b3 = 8'(y3);
    endtask

    // Vector k of the skewed job; k >= 5 is idle. mx replaces nonzeros by 255.
    task automatic apply(input int k, input bit mx);
        int unsigned v [6];
        for (int n = 0; n < 6; n++) begin
            if (k < 5) v[n] = tbl[k][n];
            else       v[n] = 0;
            if (mx && v[n] != 0) v[n] = 255;
        end
        set_in(v[0], v[1], v[2], v[3], v[4], v[5]);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'd0) begin
                errors++;
                $display("FAIL reset_init c%0d got=%0d want=0", n + 1, cv[n]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        set_in(5, 0, 0, 6, 0, 0);
        edge_step();
        checks++;
        if (c1 !== 17'd30) begin
            errors++;
            $display("FAIL reset_pre c1 got=%0d want=30", c1);
        end
        @(negedge clk);
        #2;
        set_in($urandom_range(1, 255), $urandom_range(1, 255),
               $urandom_range(1, 255), $urandom_range(1, 255),
               $urandom_range(1, 255), $urandom_range(1, 255));
        reset = 1'b1;
        #1;
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'd0) begin
                errors++;
                $display("FAIL reset_async c%0d got=%0d want=0", n + 1, cv[n]);
            end
        end
        edge_step();
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'd0) begin
                errors++;
                $display("FAIL reset_hold c%0d got=%0d want=0", n + 1, cv[n]);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        // Forwarded registers must be zero: PE(0,1) and PE(1,0) see one stale side.
        @(negedge clk);
        set_in(0, 1, 0, 0, 1, 0);
        edge_step();
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'd0) begin
                errors++;
                $display("FAIL reset_stale c%0d got=%0d want=0", n + 1, cv[n]);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_skewed_multiply();
        reset_pulse();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            apply(k, 1'b0);
            edge_step();
            if (k == 2) begin
                checks++;
                if (c1 !== 17'd28) begin
                    errors++;
                    $display("FAIL skew_c1_edge2 got=%0d want=28", c1);
                end
            end
            if (k == 5) begin
                checks++;
                if (c9 !== 17'd77) begin
                    errors++;
                    $display("FAIL skew_c9_edge5 got=%0d want=77", c9);
                end
            end
        end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'(exp_c[n])) begin
                errors++;
                $display("FAIL skew c%0d got=%0d want=%0d", n + 1, cv[n], exp_c[n]);
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            apply(5, 1'b0);
            edge_step();
        end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'(exp_c[n])) begin
                errors++;
                $display("FAIL skew_hold c%0d got=%0d want=%0d", n + 1, cv[n], exp_c[n]);
            end
        end
    endtask

    task automatic test_latency();
        reset_pulse();
        @(negedge clk);
        set_in(3, 0, 0, 3, 0, 0);
        edge_step();
        checks++;
        if (c1 !== 17'd9) begin
            errors++;
            $display("FAIL latency_c1 got=%0d want=9", c1);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) edge_step();
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== ((n == 0) ? 17'd9 : 17'd0)) begin
                errors++;
                $display("FAIL latency_hold c%0d got=%0d want=%0d",
                         n + 1, cv[n], (n == 0) ? 9 : 0);
            end
        end
    endtask

    task automatic test_max_operands();
        logic [16:0] want;
`ifdef SYSTOLIC_ACC_SAT_EN
        want = 17'd131071;
`else
        want = 17'd64003;
`endif
        reset_pulse();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            apply(k, 1'b1);
            edge_step();
        end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== want) begin
                errors++;
                $display("FAIL max c%0d got=%0d want=%0d", n + 1, cv[n], want);
            end
        end
    endtask

    task automatic test_reset_midrun();
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            apply(k, 1'b0);
            edge_step();
        end
        @(negedge clk);
        apply(4, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'd0) begin
                errors++;
                $display("FAIL midrun_clear c%0d got=%0d want=0", n + 1, cv[n]);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) edge_step();
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'd0) begin
                errors++;
                $display("FAIL midrun_after c%0d got=%0d want=0", n + 1, cv[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_pulse();
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                apply(k, 1'b0);
                edge_step();
            end
        end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (cv[n] !== 17'(2 * exp_c[n])) begin
                errors++;
                $display("FAIL b2b c%0d got=%0d want=%0d", n + 1, cv[n], 2 * exp_c[n]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        test_reset();
        test_skewed_multiply();
        test_latency();
        test_max_operands();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
